uart_rx_fifo: RTL
=================

# uart_rx_fifo

Serial receive endpoint for the SoC UART link. It is the receiving end of the 8N1 line that the SoC drives on `uart_tx`. It oversamples an asynchronous line with a fixed clock divider, deframes bytes LSB-first, and buffers them in a small show-ahead FIFO. Downstream logic drains the FIFO through a valid/ready handshake. It is used in the bench and on the FPGA top to capture firmware UART output.

## Interface
Parameters:
- `DIV`, default 868: clock cycles per bit (100 MHz / 115200); legal range ≥ 4, must be even.
- `DEPTH`, default 8: FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_i`  in  1  asynchronous serial line; idles high.
- `rx_data_o`  out  8  FIFO head byte; valid only while `rx_valid_o` = 1.
- `rx_valid_o`  out  1  FIFO not empty.
- `rx_ready_i`  in  1  consumer accepts the head byte.
- `level_o`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overrun_o`  out  1  one-cycle pulse: a good byte was dropped because the FIFO was full.
- `frame_err_o`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err_o`  out  1  one-cycle pulse: parity mismatch (see Configuration).

## Operation
- `rx_i` passes through a 2-flop synchronizer; the FSM sees only the synchronized signal `rxs`.
- FSM states:
  - IDLE: on `rxs`=0, load the counter with DIV/2−1 and go to START.
  - START: when the counter expires, resample. If `rxs`=1 it was a glitch: return to IDLE with nothing reported. If `rxs`=0, load DIV−1 and go to DATA.
  - DATA: every DIV cycles, sample `rxs` into shift bit 7 and shift right (LSB first). After 8 samples, go to PARITY if enabled, otherwise STOP.
  - PARITY (enabled only): sample one bit DIV cycles after the last data bit.
  - STOP: sample DIV cycles later.
    - `rxs`=1 with no parity error: push the byte and return to IDLE.
    - `rxs`=0: pulse `frame_err_o`, discard the byte, go to BREAK.
    - Parity error with good stop: pulse `parity_err_o`, discard the byte, return to IDLE.
  - BREAK: wait for `rxs`=1, then go to IDLE.
- FIFO:
  - Circular buffer with separate read and write pointers; the extra occupancy bit distinguishes full from empty.
  - Pop when `rx_valid_o` && `rx_ready_i`.
  - A push into a full FIFO drops the new byte and pulses `overrun_o`. The FIFO contents are unchanged.
  - A push and a pop in the same cycle while full: the pop frees a slot, the push succeeds, there is no overrun, and `level_o` is unchanged.
  - A push and a pop in the same cycle while empty: a push with `rx_valid_o` low cannot pop, so `level_o` becomes 1.
  - A pop when empty is not possible, because `rx_valid_o` is 0.
- Pointers wrap modulo DEPTH. `level_o` never exceeds DEPTH.

## Timing
- Reset values:
  - FSM in BREAK, so the receiver waits for an idle-high line before accepting a start.
  - Synchronizer flops = 1; pointers = 0.
  - `rx_valid_o`=0, `rx_data_o`=8'h00, `level_o`=0.
  - `overrun_o`=`frame_err_o`=`parity_err_o`=0.
- Reset asserted mid-frame: the partial byte is discarded, FIFO contents are lost, and the receiver resynchronizes on the next high-to-low edge after the line returns high.
- Sample schedule, with edge E0 being the first `clk` edge at which synchronizer flop 1 captures `rx_i`=0:
  - Start sample at E0+1+DIV/2.
  - Data bit k (k=0..7) at E0+1+DIV/2+DIV·(k+1).
  - Stop sample at E0+1+DIV/2+9·DIV; +10·DIV with parity.
- FIFO write occurs on the stop-sample edge. `rx_valid_o` and `rx_data_o` are valid in the cycle following that edge.
- Error pulses are asserted in the cycle following the stop-sample edge.
- `rx_data_o` is show-ahead: after a pop, the next entry appears in the next cycle.
- Back-to-back frames are accepted: IDLE is re-entered on the cycle following the stop sample.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is 8E1, with an even-parity bit between data bit 7 and stop. A mismatch pulses `parity_err_o` and the byte is not pushed. The stop sample moves to +10·DIV.
- `UART_RX_PARITY_EN` undefined: frame is 8N1, the PARITY state is absent, and `parity_err_o` is tied to 0.

## Test plan
- DIV=16, line sends 0x55 then 0xA3 back-to-back, `rx_ready_i`=1 → two pops, 0x55 then 0xA3; the first `rx_valid_o` rises at E0+154.
- `rx_ready_i`=0, DEPTH=8, send 9 bytes 0x00..0x08 → `level_o`=8, one `overrun_o` pulse on the ninth byte; the drain returns 0x00..0x07.
- FIFO full, send a byte while popping in its stop-sample cycle → no overrun, `level_o` stays 8, and the new byte is the last entry.
- 0x3C sent with stop bit 0 and the line held low for 3·DIV → one `frame_err_o` pulse, `level_o`=0; the next frame 0x7E is received correctly.
- 4-cycle low glitch on an idle line → no state change beyond START, no error pulses, `level_o`=0.
- `rst` asserted during bit 4 of a frame → all outputs return to reset values; the next full frame 0xC3 is received correctly. With `UART_RX_PARITY_EN`, 0xC3 sent with a wrong parity bit → one `parity_err_o` pulse and nothing pushed.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (oversampled by a fixed divider) feeding a show-ahead FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx_fifo #(
    parameter int DIV   = 868,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_i,
    output logic [7:0]             rx_data_o,
    output logic                   rx_valid_o,
    input  logic                   rx_ready_i,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   overrun_o,
    output logic                   frame_err_o,
    output logic                   parity_err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] C_HALF  = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] C_FULL  = CW'(DIV - 1);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    logic          r_sync1, r_sync2;
    logic          w_rxs;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [2:0]    r_bits, w_bits_nxt;
    logic          w_push;
    logic          w_frame_err;
`ifdef UART_RX_PARITY_EN
    logic          r_par_bad, w_par_bad_nxt;
    logic          w_par_err;
    logic          r_par_err;
`endif

    logic [7:0]    r_mem [DEPTH];
    logic [LW-1:0] r_wr, r_rd;
    logic [LW-1:0] w_level;
    logic          w_full, w_pop, w_wr_en;
    logic          r_overrun, r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_BREAK;
            r_cnt   <= '0;
            r_shift <= '0;
            r_bits  <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_bits  <= w_bits_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
        w_shift_nxt = r_shift;
        w_bits_nxt  = r_bits;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt = r_par_bad;
        w_par_err     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_rxs) begin
                    w_cnt_nxt   = C_HALF;
                    w_state_nxt = S_START;
                end
            end
            // IDLE reacts one cycle after the synchronizer output falls, so the
            // start sample fires at count 1 to stay centred on the start bit.
            S_START: begin
                if (r_cnt == C_ONE) begin
                    if (w_rxs) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt   = C_FULL;
                        w_bits_nxt  = '0;
                        w_state_nxt = S_DATA;
`ifdef UART_RX_PARITY_EN
                        w_par_bad_nxt = 1'b0;
`endif
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == '0) begin
                    w_shift_nxt = {w_rxs, r_shift[7:1]};
                    w_cnt_nxt   = C_FULL;
                    w_bits_nxt  = r_bits + 3'd1;
                    if (r_bits == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == '0) begin
                    w_par_bad_nxt = w_rxs ^ (^r_shift);
                    w_cnt_nxt     = C_FULL;
                    w_state_nxt   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == '0) begin
                    if (!w_rxs) begin
                        w_frame_err = 1'b1;
                        w_state_nxt = S_BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (r_par_bad) begin
                        w_par_err   = 1'b1;
                        w_state_nxt = S_IDLE;
`endif
                    end else begin
                        w_push      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                if (w_rxs) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_BREAK;
        endcase
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_level = r_wr - r_rd;
    assign w_full  = (w_level == C_DEPTH);
    assign w_pop   = rx_valid_o & rx_ready_i;
    assign w_wr_en = w_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr[AW-1:0]] <= r_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err   <= 1'b0;
`endif
        end else begin
            if (w_wr_en) r_wr <= r_wr + 1'b1;
            if (w_pop)   r_rd <= r_rd + 1'b1;
            r_overrun   <= w_push & w_full & ~w_pop;
            r_frame_err <= w_frame_err;
`ifdef UART_RX_PARITY_EN
            r_par_err   <= w_par_err;
`endif
        end
    end

    assign rx_valid_o  = (w_level != '0);
    assign rx_data_o   = rx_valid_o ? r_mem[r_rd[AW-1:0]] : 8'h00;
    assign level_o     = w_level;
    assign overrun_o   = r_overrun;
    assign frame_err_o = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = r_par_err;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule
